// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus.
package mips_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [BE_W-1:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_I = 1'b0,
        M_D = 1'b1
    } master_t;

    // Command presented to the shared Avalon-MM slave.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
    } avm_cmd_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Saturating stall counter; flags the cycle on which MAX_WAIT stalls have been seen.
module bus_wait_timer #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expire
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;

    // Count stalled cycles, hold at the top value instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (stall && (wait_cnt != CW'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // The current stalled cycle is the MAX_WAIT-th one.
    always_comb begin
        expire = stall && (wait_cnt == CW'(MAX_WAIT - 1));
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter putting the fetch and load/store ports onto one Avalon-MM slave.
module avalon_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned       MAX_WAIT = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic [31:0]       i_readdata,
    output logic              i_waitrequest,
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [3:0]        d_byteenable,
    input  logic [31:0]       d_writedata,
    output logic [31:0]       d_readdata,
    output logic              d_waitrequest,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              timeout
);

    arb_state_t state;
    master_t    last_grant;
    avm_cmd_t   cmd;

    logic req_i;
    logic req_d;
    logic in_grant;
    logic gnt_req;
    logic expire;
    logic abort;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // Granted-master request and watchdog abort qualification.
    always_comb begin
        in_grant = 1'b0;
        gnt_req  = 1'b0;
        case (state)
            GRANT_I: begin
                in_grant = 1'b1;
                gnt_req  = req_i;
            end
            GRANT_D: begin
                in_grant = 1'b1;
                gnt_req  = req_d;
            end
            default: ;
        endcase
        abort = in_grant && gnt_req && expire;
    end

    // Counter is held clear in IDLE, so every grant starts from zero.
    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_grant),
        .stall  (in_grant && avm_waitrequest),
        .expire (expire)
    );

    // Arbitration FSM, round-robin history and the registered timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= M_D;
            timeout    <= 1'b0;
        end else begin
            timeout <= abort;
            case (state)
                IDLE: begin
                    if (req_i && (!req_d || (last_grant == M_D))) begin
                        state <= GRANT_I;
                    end else if (req_d) begin
                        state <= GRANT_D;
                    end
                end
                GRANT_I: begin
                    if (!req_i) begin
                        state <= IDLE;
                    end else if (!avm_waitrequest || abort) begin
                        state      <= IDLE;
                        last_grant <= M_I;
                    end
                end
                GRANT_D: begin
                    if (!req_d) begin
                        state <= IDLE;
                    end else if (!avm_waitrequest || abort) begin
                        state      <= IDLE;
                        last_grant <= M_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave command and master responses steered by the current grant.
    always_comb begin
        cmd           = '0;
        i_waitrequest = req_i;
        d_waitrequest = req_d;
        i_readdata    = '0;
        d_readdata    = '0;
        case (state)
            GRANT_I: begin
                cmd.address    = i_address;
                cmd.read       = i_read;
                cmd.byteenable = BE_WORD;
                i_waitrequest  = avm_waitrequest && !abort;
                i_readdata     = abort ? ERR_DATA : avm_readdata;
            end
            GRANT_D: begin
                cmd.address    = d_address;
                cmd.read       = d_read && !d_write;
                cmd.write      = d_write;
                cmd.byteenable = d_byteenable;
                cmd.writedata  = d_writedata;
                d_waitrequest  = avm_waitrequest && !abort;
                d_readdata     = (abort && !d_write) ? ERR_DATA : avm_readdata;
            end
            default: ;
        endcase
    end

    assign avm_address    = cmd.address;
    assign avm_read       = cmd.read;
    assign avm_write      = cmd.write;
    assign avm_byteenable = cmd.byteenable;
    assign avm_writedata  = cmd.writedata;

endmodule
